// File: rtl/gemm_requant_pkg.sv
// Shared constants, FSM encoding and requantisation helpers for the gemm_requant output stage.
// The helpers are also usable by reference models outside the RTL.
package gemm_requant_pkg;

    localparam int LANES      = 4;
    localparam int ACC_W      = 32;
    localparam int OUT_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W:0]           CREDITS   = FIFO_DEPTH[CNT_W:0];
    localparam logic signed [2*ACC_W-1:0] Q31_HALF  = 64'sh0000_0000_4000_0000;
    localparam logic signed [2*ACC_W-1:0] Q31_SAT_P = 64'sh4000_0000_0000_0000;
    localparam logic signed [ACC_W-1:0]   ACC_MAX   = 32'sh7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic signed [2*ACC_W-1:0] mul_q31(
        input logic signed [ACC_W-1:0] x,
        input logic signed [ACC_W-1:0] m
    );
        logic signed [2*ACC_W-1:0] xe;
        logic signed [2*ACC_W-1:0] me;
        xe = x;
        me = m;
        mul_q31 = xe * me;
    endfunction

    // Only (-2^31)*(-2^31) yields 2^62, the one product whose rounded high half overflows int32.
    function automatic logic signed [ACC_W-1:0] q31_round(
        input logic signed [2*ACC_W-1:0] p
    );
        logic signed [2*ACC_W-1:0] t;
        t = (p + Q31_HALF) >>> 6'd31;
        if (p == Q31_SAT_P) begin
            q31_round = ACC_MAX;
        end else begin
            q31_round = ACC_W'(t);
        end
    endfunction

    function automatic logic signed [OUT_W-1:0] shift_clamp(
        input logic signed [ACC_W-1:0] h,
        input logic [4:0]              sh,
        input logic signed [8:0]       ofs,
        input logic signed [OUT_W-1:0] lo,
        input logic signed [OUT_W-1:0] hi
    );
        logic [ACC_W-1:0]        mask;
        logic [ACC_W-1:0]        rem;
        logic [ACC_W-1:0]        thr;
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W:0]   r_x;
        logic signed [ACC_W:0]   o_x;
        logic signed [ACC_W:0]   lo_x;
        logic signed [ACC_W:0]   hi_x;
        logic signed [ACC_W:0]   y;
        mask = (32'd1 << sh) - 32'd1;
        rem  = h & mask;
        thr  = (mask >> 1) + {31'd0, h[ACC_W-1]};
        r    = h >>> sh;
        if (rem > thr) begin
            r = r + 32'sd1;
        end else begin
            r = r;
        end
        r_x  = r;
        o_x  = ofs;
        lo_x = lo;
        hi_x = hi;
        y    = r_x + o_x;
        if (y < lo_x) begin
            shift_clamp = lo;
        end else if (y > hi_x) begin
            shift_clamp = hi;
        end else begin
            shift_clamp = y[OUT_W-1:0];
        end
    endfunction

    function automatic logic signed [OUT_W-1:0] requant_lane(
        input logic signed [ACC_W-1:0] x,
        input logic signed [ACC_W-1:0] m,
        input logic [4:0]              sh,
        input logic signed [8:0]       ofs,
        input logic signed [OUT_W-1:0] lo,
        input logic signed [OUT_W-1:0] hi
    );
        requant_lane = shift_clamp(q31_round(mul_q31(x, m)), sh, ofs, lo, hi);
    endfunction

endpackage

// File: rtl/gemm_requant_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count for the requant output words.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module gemm_requant_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    // Handshake qualification.
    always_comb begin
        pop_s  = rd_en && (count_r != {CW{1'b0}});
        push_s = wr_en && ((count_r != CNT_FULL) || pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= (wr_ptr_r == PTR_LAST) ? {AW{1'b0}} : wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {AW{1'b0}} : rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign empty   = (count_r == {CW{1'b0}});

endmodule

// File: rtl/gemm_requant.sv
// Post-GEMM requantisation stage: reads C rows, requantises 4 int32 lanes to int8, emits packed words.
// Optional macro REQUANT_BIAS_EN adds a per-lane int32 bias port applied before the multiply.
module gemm_requant
    import gemm_requant_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              rows,
    input  logic [31:0]              multiplier,
    input  logic [4:0]               shift,
    input  logic [8:0]               out_offset,
    input  logic [7:0]               act_min,
    input  logic [7:0]               act_max,
`ifdef REQUANT_BIAS_EN
    input  logic [LANES*ACC_W-1:0]   bias,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              C_index,
    input  logic [LANES*ACC_W-1:0]   C_data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data
);

    state_t                   state_r;
    state_t                   state_next_s;
    logic [15:0]              rows_r;
    logic signed [ACC_W-1:0]  mult_r;
    logic [4:0]               shift_r;
    logic signed [8:0]        ofs_r;
    logic signed [OUT_W-1:0]  min_r;
    logic signed [OUT_W-1:0]  max_r;
`ifdef REQUANT_BIAS_EN
    logic [LANES*ACC_W-1:0]   bias_r;
`endif
    logic [15:0]              row_cnt_r;
    logic [15:0]              c_index_r;
    logic                     issue_v_r;
    logic                     rd_v_r;
    logic                     s1_v_r;
    logic                     s2_v_r;
    logic signed [ACC_W-1:0]  s1_x_r [LANES];
    logic signed [2*ACC_W-1:0] s2_p_r [LANES];
    logic [CNT_W-1:0]         inflight_r;
    logic [CNT_W-1:0]         fifo_count_s;
    logic [CNT_W:0]           credit_use_s;
    logic                     fifo_empty_s;
    logic                     pop_s;
    logic                     issue_s;
    logic                     last_s;
    logic                     start_acc_s;
    logic                     busy_r;
    logic                     done_r;
    logic [LANES*OUT_W-1:0]   res_s;
    logic [LANES*OUT_W-1:0]   fifo_head_s;

    // Issue qualification: reads already in flight plus queued words must never exceed FIFO depth.
    always_comb begin
        credit_use_s = {1'b0, fifo_count_s} + {1'b0, inflight_r};
        start_acc_s  = (state_r == IDLE) && start;
        last_s       = (row_cnt_r == (rows_r - 16'd1));
        pop_s        = !fifo_empty_s && out_ready;
        if ((state_r == RUN) && (credit_use_s < CREDITS)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (rows == 16'd0) ? DONE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && last_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if ((fifo_count_s == {CNT_W{1'b0}}) && (inflight_r == {CNT_W{1'b0}})) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register with registered busy/done; busy stays high through the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE) || (state_r == DONE);
            done_r  <= (state_r == DONE);
        end
    end

    // Configuration captured on an accepted start and held for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_r  <= 16'd0;
            mult_r  <= 32'sd0;
            shift_r <= 5'd0;
            ofs_r   <= 9'sd0;
            min_r   <= 8'sd0;
            max_r   <= 8'sd0;
`ifdef REQUANT_BIAS_EN
            bias_r  <= {(LANES*ACC_W){1'b0}};
`endif
        end else if (start_acc_s) begin
            rows_r  <= rows;
            mult_r  <= multiplier;
            shift_r <= shift;
            ofs_r   <= out_offset;
            min_r   <= act_min;
            max_r   <= act_max;
`ifdef REQUANT_BIAS_EN
            bias_r  <= bias;
`endif
        end
    end

    // Address issue and in-flight read accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_r  <= 16'd0;
            c_index_r  <= 16'd0;
            issue_v_r  <= 1'b0;
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            issue_v_r <= issue_s;
            if (start_acc_s) begin
                row_cnt_r <= 16'd0;
            end else if (issue_s) begin
                c_index_r <= row_cnt_r;
                row_cnt_r <= row_cnt_r + 16'd1;
            end
            case ({issue_s, s2_v_r})
                2'b10:   inflight_r <= inflight_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   inflight_r <= inflight_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Non-stalling datapath: memory data capture, then 64-bit products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v_r <= 1'b0;
            s1_v_r <= 1'b0;
            s2_v_r <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_x_r[i] <= 32'sd0;
                s2_p_r[i] <= 64'sd0;
            end
        end else begin
            rd_v_r <= issue_v_r;
            s1_v_r <= rd_v_r;
            s2_v_r <= s1_v_r;
            if (rd_v_r) begin
                for (int i = 0; i < LANES; i++) begin
`ifdef REQUANT_BIAS_EN
                    s1_x_r[i] <= C_data_out[ACC_W*i +: ACC_W] + bias_r[ACC_W*i +: ACC_W];
`else
                    s1_x_r[i] <= C_data_out[ACC_W*i +: ACC_W];
`endif
                end
            end
            if (s1_v_r) begin
                for (int i = 0; i < LANES; i++) begin
                    s2_p_r[i] <= mul_q31(s1_x_r[i], mult_r);
                end
            end
        end
    end

    // Round, shift, offset and clamp each lane straight into the FIFO write port.
    always_comb begin
        res_s = {(LANES*OUT_W){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            res_s[OUT_W*i +: OUT_W] = shift_clamp(q31_round(s2_p_r[i]), shift_r, ofs_r, min_r, max_r);
        end
    end

    gemm_requant_fifo #(
        .WIDTH (LANES*OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s2_v_r),
        .wr_data (res_s),
        .rd_en   (pop_s),
        .rd_data (fifo_head_s),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign C_index   = c_index_r;
    assign out_valid = !fifo_empty_s;
    assign out_data  = fifo_head_s;

endmodule
